// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared FSM encoding and default bank geometry for the fnn weight path
package fnn_pkg;

  localparam int FNN_BANK_W    = 496;
  localparam int FNN_NUM_BANKS = 4;
  localparam int FNN_LAST_W    = 240;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } wbs_state_e;

endpackage

// File: rtl/weight_bank_seq_bank_extract.sv
// rtl/weight_bank_seq_bank_extract.sv - selects one bank from the flat bus, zero-extending the short final bank
module bank_extract
  import fnn_pkg::*;
#(
  parameter int BANK_W    = FNN_BANK_W,
  parameter int NUM_BANKS = FNN_NUM_BANKS,
  parameter int LAST_W    = FNN_LAST_W,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic [(NUM_BANKS-1)*BANK_W+LAST_W-1:0] banks_i,
  input  logic [IDX_W-1:0]                       idx_i,
  output logic [BANK_W-1:0]                      bank_o
);

  always_comb begin
    bank_o = '0;
    for (int b = 0; b < NUM_BANKS - 1; b++) begin
      if (idx_i == IDX_W'(b)) bank_o = banks_i[b*BANK_W +: BANK_W];
    end
    if (idx_i == IDX_W'(NUM_BANKS - 1)) bank_o[LAST_W-1:0] = banks_i[(NUM_BANKS-1)*BANK_W +: LAST_W];
  end

endmodule

// File: rtl/weight_bank_seq.sv
// rtl/weight_bank_seq.sv - streams one bank or a full sweep of weight banks over a valid/ready beat interface
module weight_bank_seq
  import fnn_pkg::*;
#(
  parameter int BANK_W    = FNN_BANK_W,
  parameter int NUM_BANKS = FNN_NUM_BANKS,
  parameter int LAST_W    = FNN_LAST_W,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [(NUM_BANKS-1)*BANK_W+LAST_W-1:0] banks,
  input  logic                                   start,
  input  logic                                   sweep,
  input  logic [IDX_W-1:0]                       sel,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [BANK_W-1:0]                      out_data,
  output logic [IDX_W-1:0]                       out_idx,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

  wbs_state_e        state_q, state_d;
  logic              sweep_q, sweep_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BANK_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  load_idx;
  logic [BANK_W-1:0] ext_bank;
  logic              sel_oob;

  // Index of the beat that would be loaded on this edge: the first beat from IDLE, else the successor.
  always_comb begin
    load_idx = idx_q + IDX_W'(1);
    if (state_q == ST_IDLE) load_idx = sweep ? '0 : sel;
  end

  assign sel_oob = !sweep && ({1'b0, sel} >= (IDX_W+1)'(NUM_BANKS));

  bank_extract #(
    .BANK_W   (BANK_W),
    .NUM_BANKS(NUM_BANKS),
    .LAST_W   (LAST_W),
    .IDX_W    (IDX_W)
  ) u_extract (
    .banks_i(banks),
    .idx_i  (load_idx),
    .bank_o (ext_bank)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sweep_d = sweep;
          if (sel_oob) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = ST_SEND;
            idx_d   = load_idx;
            data_d  = ext_bank;
            last_d  = !sweep || (load_idx == LAST_IDX);
            err_d   = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_FIN;
            err_d   = 1'b0;
          end else begin
            idx_d  = load_idx;
            data_d = ext_bank;
            last_d = !sweep_q || (load_idx == LAST_IDX);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sweep_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign err       = done && err_q;

endmodule

// File: tb/tb_weight_bank_seq.sv
// tb/tb_weight_bank_seq.sv - directed scoreboard bench for weight_bank_seq
module tb_weight_bank_seq;

  localparam int BW  = 496;
  localparam int NB  = 4;
  localparam int LW  = 240;
  localparam int IW  = 2;
  localparam int TW  = (NB-1)*BW + LW;
  localparam int NB3 = 3;
  localparam int TW3 = (NB3-1)*BW + LW;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] banks;
  logic          start, sweep, out_ready;
  logic [IW-1:0] sel;
  logic          out_valid, out_last, busy, done, err;
  logic [BW-1:0] out_data;
  logic [IW-1:0] out_idx;

  logic           start3, sweep3, out_ready3;
  logic [TW3-1:0] banks3;
  logic [IW-1:0]  sel3;
  logic           out_valid3, out_last3, busy3, done3, err3;
  logic [BW-1:0]  out_data3;
  logic [IW-1:0]  out_idx3;

  beat_t         exp_q[$];
  logic [BW-1:0] bank_val[NB];
  logic [BW-1:0] saved;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc;

  always #5 clk = ~clk;

  weight_bank_seq u_dut (
    .clk(clk), .rst_n(rst_n), .banks(banks), .start(start), .sweep(sweep), .sel(sel),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  weight_bank_seq #(.NUM_BANKS(NB3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .banks(banks3), .start(start3), .sweep(sweep3), .sel(sel3),
    .out_ready(out_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_idx(out_idx3),
    .out_last(out_last3), .busy(busy3), .done(done3), .err(err3)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_banks();
    banks  = {bank_val[3][LW-1:0], bank_val[2], bank_val[1], bank_val[0]};
    banks3 = {bank_val[2][LW-1:0], bank_val[1], bank_val[0]};
  endtask

  function automatic logic [BW-1:0] exp_data(input int i);
    if (i == NB-1) return {{(BW-LW){1'b0}}, bank_val[i][LW-1:0]};
    return bank_val[i];
  endfunction

  task automatic push_beat(input int i, input logic last);
    beat_t b;
    b.idx  = IW'(i);
    b.data = exp_data(i);
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NB; i++) push_beat(i, i == NB-1);
  endtask

  // Score any handshake on the falling edge, then advance to just after the next rising edge.
  task automatic step();
    beat_t b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("beat_idx", out_idx, b.idx);
        check("beat_data", out_data, b.data);
        check("beat_last", out_last, b.last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input int max_cyc, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < max_cyc) begin
      step();
      cycles++;
    end
    check("drain_within_bound", exp_q.size() == 0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"},  out_data, '0);
    check({tag, "_idx"},   out_idx, '0);
    check({tag, "_last"},  out_last, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_err"},   err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sweep = 1'b0; sel = '0; out_ready = 1'b0;
    start3 = 1'b0; sweep3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
    for (int i = 0; i < NB; i++)
      for (int w = 0; w < 16; w++) bank_val[i][w*31 +: 31] = 31'($urandom);
    build_banks();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Full sweep with ready held high.
    out_ready = 1'b1; sweep = 1'b1; start = 1'b1;
    push_sweep();
    step();
    start = 1'b0;
    check("s1_first_valid", out_valid, 1'b1);
    check("s1_first_idx", out_idx, 2'd0);
    check("s1_busy", busy, 1'b1);
    run_drain(10, cyc);
    check("s1_cycles", cyc, 4);
    check("s1_done", done, 1'b1);
    check("s1_fin_valid", out_valid, 1'b0);
    check("s1_err", err, 1'b0);
    step();
    check("s1_done_pulse", done, 1'b0);
    check("s1_idle", busy, 1'b0);

    // Single beat of the short final bank.
    bank_val[3] = '0;
    bank_val[3][0] = 1'b1;
    build_banks();
    sweep = 1'b0; sel = 2'd3; start = 1'b1;
    push_beat(3, 1'b1);
    step();
    start = 1'b0;
    check("s2_data_one", out_data, 496'h1);
    check("s2_last", out_last, 1'b1);
    run_drain(5, cyc);
    check("s2_done", done, 1'b1);
    check("s2_err", err, 1'b0);
    step();

    // Back-pressure on idx 1; banks change while stalled must not leak into the held beat.
    sweep = 1'b1; start = 1'b1;
    push_sweep();
    step();
    start = 1'b0;
    step();
    out_ready = 1'b0;
    saved = exp_data(1);
    bank_val[1] = ~bank_val[1];
    build_banks();
    for (int k = 0; k < 3; k++) begin
      check("s3_stall_valid", out_valid, 1'b1);
      check("s3_stall_idx", out_idx, 2'd1);
      check("s3_stall_data", out_data, saved);
      step();
    end
    check("s3_hold4_idx", out_idx, 2'd1);
    out_ready = 1'b1;
    step();
    check("s3_next_idx", out_idx, 2'd2);
    run_drain(10, cyc);
    check("s3_done", done, 1'b1);
    step();

    // Out-of-range sel on a 3-bank instance.
    sweep3 = 1'b0; sel3 = 2'd3; start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("s4_no_valid", out_valid3, 1'b0);
    check("s4_done", done3, 1'b1);
    check("s4_err", err3, 1'b1);
    step();
    check("s4_done_pulse", done3, 1'b0);
    check("s4_err_pulse", err3, 1'b0);
    check("s4_idle", busy3, 1'b0);

    // Asynchronous reset during idx 2 of a sweep, then a clean restart.
    sweep = 1'b1; start = 1'b1;
    push_sweep();
    step();
    start = 1'b0;
    step();
    step();
    check("s5_at_idx2", out_idx, 2'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("s5_async");
    exp_q.delete();
    step();
    step();
    check_all_zero("s5_held");
    rst_n = 1'b1;
    step();
    start = 1'b1;
    push_sweep();
    step();
    start = 1'b0;
    check("s5_restart_valid", out_valid, 1'b1);
    check("s5_restart_idx", out_idx, 2'd0);
    run_drain(10, cyc);
    check("s5_cycles", cyc, 4);
    check("s5_done", done, 1'b1);
    step();

    // A start pulse during SEND must be ignored.
    out_ready = 1'b0; sweep = 1'b1; start = 1'b1;
    push_sweep();
    step();
    check("s6_first_idx", out_idx, 2'd0);
    sweep = 1'b0; sel = 2'd3;
    step();
    start = 1'b0; sweep = 1'b1;
    check("s6_idx_kept", out_idx, 2'd0);
    check("s6_last_kept", out_last, 1'b0);
    out_ready = 1'b1;
    run_drain(10, cyc);
    check("s6_cycles", cyc, 4);
    check("s6_done", done, 1'b1);
    check("s6_err", err, 1'b0);
    step();
    check("s6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bank_seq.md
WEIGHT_BANK_SEQ -- requirements
Module: weight_bank_seq

Interface
REQ-001 SHALL have parameter BANK_W, default 496, meaning the width of one full weight bank in bits.
REQ-002 SHALL have parameter NUM_BANKS, default 4, meaning the number of banks, which is at least 2.
REQ-003 SHALL have parameter LAST_W, default 240, meaning the valid width of the final bank, where LAST_W <= BANK_W.
REQ-004 SHALL have parameter IDX_W, default $clog2(NUM_BANKS), meaning the width of a bank index.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; everything is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port banks, input, (NUM_BANKS-1)*BANK_W+LAST_W bits: flat bank bus with bank 0 at the LSBs and the final bank LAST_W bits wide at the MSBs.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request pulse.
REQ-009 SHALL have port sweep, input, 1 bit, sampled with start: 1 = stream all banks, 0 = single bank.
REQ-010 SHALL have port sel, input, IDX_W bits, sampled with start: the bank index in single mode.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_data, output, BANK_W bits: selected bank, zero-extended.
REQ-014 SHALL have port out_idx, output, IDX_W bits: index of the bank currently presented.
REQ-015 SHALL have port out_last, output, 1 bit: final beat of the transaction.
REQ-016 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when a transaction ends.
REQ-018 SHALL have port err, output, 1 bit: valid with done; high for an out-of-range sel.

Function
REQ-019 SHALL implement FSM states IDLE, SEND and FIN.
REQ-020 SHALL, in IDLE with start=1, latch sweep and sel and enter SEND on the next edge with out_valid=1, giving one cycle of latency from start to the first beat.
REQ-021 SHALL, for sweep=1, begin at index 0; for sweep=0, begin at index sel.
REQ-022 SHALL register out_data: for indices below NUM_BANKS-1 it is the full bank, and for index NUM_BANKS-1 it is {(BANK_W-LAST_W) zeros, final bank}.
REQ-023 SHALL keep out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL treat a beat as accepted when out_valid and out_ready are both 1 on the same edge.
REQ-025 SHALL, in sweep mode on an accepted non-last beat, present index+1 in the next cycle with out_valid kept at 1 and no bubble.
REQ-026 SHALL assert out_last when the index is NUM_BANKS-1 in sweep mode, and always in single mode.
REQ-027 SHALL move SEND to FIN on an accepted out_last beat; FIN lasts one cycle with done=1 and out_valid=0, then returns to IDLE.
REQ-028 SHALL, for sweep=0 with sel >= NUM_BANKS, emit no beat and go directly to FIN with done=1 and err=1.
REQ-029 SHALL ignore start while busy=1, with no effect on the latched mode or index.
REQ-030 SHALL use the banks value sampled on the edge that loads each beat; a change to banks while a beat is stalled SHALL NOT alter that beat.
REQ-031 SHALL never drive Z or X on any output.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronously, including mid-transaction), force the state to IDLE and out_valid, out_last, busy, done, err, out_idx and out_data to 0.
REQ-033 SHALL leave the bench responsible for ensuring no start pulse is lost at reset release, with the first usable start on the second edge after rst_n rises.

Structure
REQ-034 SHALL place the FSM state encoding and the default BANK_W/NUM_BANKS/LAST_W values in the shared fnn package.
REQ-035 SHALL contain one sub-module, bank_extract, a combinational function of index that selects and zero-extends a bank; the FSM and registers live in weight_bank_seq.

Verification
REQ-036 SHALL cover this scenario: sweep=1 with out_ready held at 1 -> beats idx 0,1,2,3 on consecutive cycles, out_last only on idx 3, done the cycle after.
REQ-037 SHALL cover this scenario: sweep=0, sel=3, final bank = 240'h1 -> one beat with out_data = 496'h1 (upper 256 bits zero), out_last=1, err=0.
REQ-038 SHALL cover this scenario: sweep=1 with out_ready low for 3 cycles on idx 1 -> idx 1 held stable for 4 cycles, then idx 2; no beat dropped or duplicated.
REQ-039 SHALL cover this scenario: NUM_BANKS=3 with sweep=0 and sel=3 -> no out_valid, done=1 and err=1 one cycle after start.
REQ-040 SHALL cover this scenario: rst_n pulled low during idx 2 of a sweep -> all outputs 0 at once; a new start after release restarts at idx 0.
REQ-041 SHALL cover this scenario: start pulsed during SEND -> ignored, and the transaction finishes unchanged.
